vga_timing_gen: RTL and testbench

Source of the VGA raster timing stream (hcount/vcount/hsync/hblnk/vsync/vblnk) consumed by every draw stage in the video pipeline. It is the head of the chain that the object/background/sprite drawers attach to. It produces 800x600@60 Hz timing from the 40 MHz pixel clock by default, with all outputs registered and mutually aligned.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_timing_gen_if.sv | 38 +++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared video constants: default 800x600@60 timing, count width and the RGB palette used by draw stages.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BP     = 88;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 23;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned COUNT_W = 11;
    typedef logic [COUNT_W-1:0] count_t;

    typedef logic [11:0] rgb_t;
    localparam rgb_t BLACK   = 12'h000;
    localparam rgb_t BLUE    = 12'h00F;
    localparam rgb_t GREEN   = 12'h0F0;
    localparam rgb_t CYAN    = 12'h0FF;
    localparam rgb_t RED     = 12'hF00;
    localparam rgb_t MAGENTA = 12'hF0F;
    localparam rgb_t YELLOW  = 12'hFF0;
    localparam rgb_t WHITE   = 12'hFFF;

    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and draw stages (slave).
// frame_cnt exists only when VGA_TIMING_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   en;
    count_t hcount_out;
    logic   hsync_out;
    logic   hblnk_out;
    count_t vcount_out;
    logic   vsync_out;
    logic   vblnk_out;
    logic   frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        input  en,
        output hcount_out, hsync_out, hblnk_out,
        output vcount_out, vsync_out, vblnk_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
        output frame_cnt,
`endif
        output frame_start
    );

    modport slave (
        output en,
        input  hcount_out, hsync_out, hblnk_out,
        input  vcount_out, vsync_out, vblnk_out,
`ifdef VGA_TIMING_FRAME_CNT_EN
        input  frame_cnt,
`endif
        input  frame_start
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrap counter plus sync/blank flags decoded from the next count,
// so the registered flags always describe the registered count.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE   = 800,
    parameter int unsigned FP       = 40,
    parameter int unsigned SYNC     = 128,
    parameter int unsigned TOTAL    = 1056,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   step,
    output logic   wrap,
    output count_t count,
    output logic   sync,
    output logic   blnk
);

    localparam count_t LAST       = count_t'(TOTAL - 1);
    localparam count_t ACTIVE_END = count_t'(ACTIVE);
    localparam count_t SYNC_START = count_t'(ACTIVE + FP);
    localparam count_t SYNC_END   = count_t'(ACTIVE + FP + SYNC);

    count_t count_q, count_d;
    logic   sync_q, sync_d;
    logic   blnk_q, blnk_d;

    always_comb begin
        wrap    = step && (count_q == LAST);
        count_d = count_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + count_t'(1);
        end
        blnk_d = (count_d >= ACTIVE_END);
        sync_d = sync_level((count_d >= SYNC_START) && (count_d < SYNC_END), SYNC_POL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            sync_q  <= ~SYNC_POL;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blnk_q  <= blnk_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Head of the video pipeline: registered, zero-skew VGA raster timing (800x600@60 by default).
// Optional frame counter output enabled by VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  tim
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic h_wrap, v_wrap, v_step;
    logic frame_start_q, frame_start_d;

    assign v_step = tim.en & h_wrap;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .TOTAL(H_TOT), .SYNC_POL(SYNC_POL)
    ) u_h_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (tim.en),
        .wrap  (h_wrap),
        .count (tim.hcount_out),
        .sync  (tim.hsync_out),
        .blnk  (tim.hblnk_out)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .TOTAL(V_TOT), .SYNC_POL(SYNC_POL)
    ) u_v_axis (
        .clk   (clk),
        .rst   (rst),
        .step  (v_step),
        .wrap  (v_wrap),
        .count (tim.vcount_out),
        .sync  (tim.vsync_out),
        .blnk  (tim.vblnk_out)
    );

    // A vertical wrap only happens together with a horizontal wrap, i.e. on entry to (0,0).
    always_comb begin
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign tim.frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (v_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tim.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: full 1056-pixel lines with a shortened 8-line frame.
// Frame counter checks are compiled in with VGA_TIMING_FRAME_CNT_EN.
module tb_vga_timing_gen;

    // Vertical axis shortened to 8 lines: active 0..3, fp 4, sync 5..6, bp 7.
    localparam int FRAME_CYC = 1056 * 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_timing_gen_if tim ();

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tim (tim)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    int   expH = 0;
    int   expV = 0;
    logic expFs = 1'b0;

    int hsCyc, hbCyc, vsCyc, fsCnt, fsIdx;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, exp h=%0d v=%0d)",
                     tag, actual, expected, $time, expH, expV);
        end
    endtask

    function automatic logic [63:0] actVec();
        return {37'd0, tim.hcount_out, tim.vcount_out,
                tim.hsync_out, tim.hblnk_out, tim.vsync_out, tim.vblnk_out, tim.frame_start};
    endfunction

    function automatic logic [63:0] expVec();
        logic hs, hb, vs, vb;
        hb = (expH >= 800);
        hs = (expH >= 840) && (expH < 968);
        vb = (expV >= 4);
        vs = (expV >= 5) && (expV < 7);
        return {37'd0, 11'(expH), 11'(expV), hs, hb, vs, vb, expFs};
    endfunction

    task automatic clearTallies();
        hsCyc = 0; hbCyc = 0; vsCyc = 0; fsCnt = 0; fsIdx = -1;
    endtask

    task automatic resetModel();
        expH = 0; expV = 0; expFs = 1'b0;
    endtask

    // mode 0: en low, 1: en high, 2: en high every other cycle. Called at a negedge.
    task automatic applyStimulus(input int cycles, input int mode);
        for (int i = 0; i < cycles; i++) begin
            tim.en = (mode == 1) || ((mode == 2) && (i % 2 == 0));
            @(posedge clk);
            expFs = 1'b0;
            if (tim.en) begin
                if (expH == 1055) begin
                    expH = 0;
                    if (expV == 7) begin
                        expV  = 0;
                        expFs = 1'b1;
                    end else begin
                        expV++;
                    end
                end else begin
                    expH++;
                end
            end
            @(negedge clk);
            checkOutput("pix", actVec(), expVec());
            if (tim.hsync_out)   hsCyc++;
            if (tim.hblnk_out)   hbCyc++;
            if (tim.vsync_out)   vsCyc++;
            if (tim.frame_start) begin
                fsCnt++;
                fsIdx = i;
            end
        end
    endtask

    initial begin
        tim.en = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_state", actVec(), 64'd0);
        rst = 1'b0;

        clearTallies();
        applyStimulus(3, 0);
        checkOutput("en_low_hold", actVec(), 64'd0);

        clearTallies();
        applyStimulus(1056, 1);
        checkOutput("line_hsync_cycles", 64'(hsCyc), 64'd128);
        checkOutput("line_hblnk_cycles", 64'(hbCyc), 64'd256);
        checkOutput("line_end_pos", {tim.hcount_out, tim.vcount_out}, {11'd0, 11'd1});

        clearTallies();
        applyStimulus(FRAME_CYC - 1056, 1);
        checkOutput("frame_vsync_cycles", 64'(vsCyc), 64'd2112);
        checkOutput("frame_fs_count", 64'(fsCnt), 64'd1);
        checkOutput("frame_fs_index", 64'(fsIdx), 64'(FRAME_CYC - 1056 - 1));

        clearTallies();
        applyStimulus(2 * FRAME_CYC, 2);
        checkOutput("half_en_fs_count", 64'(fsCnt), 64'd1);
        checkOutput("half_en_fs_index", 64'(fsIdx), 64'(2 * FRAME_CYC - 2));

        clearTallies();
        applyStimulus(3 * 1056 + 500, 1);
        checkOutput("pre_reset_pos", {tim.hcount_out, tim.vcount_out}, {11'd500, 11'd3});
        #2 rst = 1'b1;
        #1;
        resetModel();
        checkOutput("async_reset", actVec(), 64'd0);
        tim.en = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_hold", actVec(), 64'd0);
        rst = 1'b0;
        clearTallies();
        applyStimulus(20, 1);
        checkOutput("post_reset_no_fs", 64'(fsCnt), 64'd0);
        checkOutput("post_reset_pos", {tim.hcount_out, tim.vcount_out}, {11'd20, 11'd0});

`ifdef VGA_TIMING_FRAME_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        resetModel();
        checkOutput("fcnt_reset", 64'(tim.frame_cnt), 64'd0);
        rst = 1'b0;
        applyStimulus(3 * FRAME_CYC, 1);
        checkOutput("fcnt_three", 64'(tim.frame_cnt), 64'd3);
        force dut.frame_cnt_q = 16'hFFFF;
        #1 release dut.frame_cnt_q;
        applyStimulus(FRAME_CYC, 1);
        checkOutput("fcnt_wrap", 64'(tim.frame_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
